// File: rtl/apb_pkg.sv
// Shared APB definitions for the image-filter register slice.
// The requester (apb_master) and the completer both import this package.
package apb_pkg;

    // Default bus geometry for the image-filter register block.
    localparam int APB_ADDR_WIDTH = 10;
    localparam int APB_DATA_WIDTH = 32;

    // Requester transfer phases.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Image-filter register map. Each block occupies the inclusive range FIRST..LAST.
    localparam logic [APB_ADDR_WIDTH-1:0] CSC_FIRST     = 10'h000;
    localparam logic [APB_ADDR_WIDTH-1:0] CSC_LAST      = 10'h00A;
    localparam logic [APB_ADDR_WIDTH-1:0] ICSC_FIRST    = 10'h010;
    localparam logic [APB_ADDR_WIDTH-1:0] ICSC_LAST     = 10'h01A;
    localparam logic [APB_ADDR_WIDTH-1:0] FILTER1_FIRST = 10'h020;
    localparam logic [APB_ADDR_WIDTH-1:0] FILTER1_LAST  = 10'h044;
    localparam logic [APB_ADDR_WIDTH-1:0] FILTER2_FIRST = 10'h048;
    localparam logic [APB_ADDR_WIDTH-1:0] FILTER2_LAST  = 10'h06A;
    localparam logic [APB_ADDR_WIDTH-1:0] BYPASS_ADDR   = 10'h070;

    // Map block selector, handy for completer-side decoding.
    typedef enum logic [2:0] {
        BLK_NONE    = 3'd0,
        BLK_CSC     = 3'd1,
        BLK_ICSC    = 3'd2,
        BLK_FILTER1 = 3'd3,
        BLK_FILTER2 = 3'd4,
        BLK_BYPASS  = 3'd5
    } apb_block_e;

    // Decode an address into the register block that owns it.
    function automatic apb_block_e decode_block(input logic [APB_ADDR_WIDTH-1:0] addr);
        apb_block_e blk;
        blk = BLK_NONE;
        if (addr <= CSC_LAST)
            blk = BLK_CSC;
        else if (addr >= ICSC_FIRST && addr <= ICSC_LAST)
            blk = BLK_ICSC;
        else if (addr >= FILTER1_FIRST && addr <= FILTER1_LAST)
            blk = BLK_FILTER1;
        else if (addr >= FILTER2_FIRST && addr <= FILTER2_LAST)
            blk = BLK_FILTER2;
        else if (addr == BYPASS_ADDR)
            blk = BLK_BYPASS;
        return blk;
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP + ACCESS transfer,
// with an optional wait-state timeout, and returns a single-cycle response pulse.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    // Command side
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic                  i_cmd_write,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,

    // Response side (never back-pressured)
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,

    // APB requester
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic                  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic                  i_PREADY,
    input  logic [DATA_WIDTH-1:0] i_PRDATA
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e            state_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  timeout_hit;

    // NOTE: ready is decoded from the state register rather than registered,
    // so it is already high in the response cycle and a held command goes
    // straight into the next SETUP without a bubble.
    assign o_cmd_ready = (state_q == ST_IDLE);

    // Abort fires on the last allowed wait cycle; a zero TIMEOUT disables it.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

    // Transfer FSM with all bus and response outputs registered.
    // NOTE: every state element here uses non-blocking assignment so that all
    // decisions in one cycle see the pre-edge values of the other registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // The response is a one-cycle pulse; data and error hold.
            rsp_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        paddr_q   <= i_cmd_addr;
                        pwrite_q  <= i_cmd_write;
                        pwdata_q  <= i_cmd_wdata;
                    end
                end

                ST_SETUP: begin
                    state_q    <= ST_ACCESS;
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end

                ST_ACCESS: begin
                    if (i_PREADY) begin
                        // Completer finished; ready wins over a same-cycle timeout.
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : i_PRDATA;
                    end else if (timeout_hit) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_PADDR     = paddr_q;
    assign o_PSEL      = psel_q;
    assign o_PENABLE   = penable_q;
    assign o_PWRITE    = pwrite_q;
    assign o_PWDATA    = pwdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small register-file completer.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;

    // Completer modes: 0 = ready one cycle after PSEL&PENABLE,
    // 1 = never ready, 2 = ready in ACCESS cycle number ready_at (0-based).
    int comp_mode = 0;
    int ready_at  = 0;
    int acc_cnt   = 0;
    logic [31:0] mem [0:1023];

    apb_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_addr (cmd_addr),
        .i_cmd_write(cmd_write),
        .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err  (rsp_err),
        .o_PADDR    (paddr),
        .o_PSEL     (psel),
        .o_PENABLE  (penable),
        .o_PWRITE   (pwrite),
        .o_PWDATA   (pwdata),
        .i_PREADY   (pready),
        .i_PRDATA   (prdata)
    );

    always #5 clk = ~clk;

    assign prdata = mem[paddr];

    // Completer model: registered PREADY, write on completion.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pready  <= 1'b0;
            acc_cnt <= 0;
        end else begin
            if (psel && penable && pready && pwrite)
                mem[paddr] <= pwdata;
            acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
            case (comp_mode)
                0:       pready <= psel && penable && !pready;
                2:       pready <= psel && penable && !pready && (acc_cnt == ready_at - 1);
                default: pready <= 1'b0;
            endcase
        end
    end

    // One transfer from a fresh IDLE; cycle 0 ends at the accepting edge.
    task automatic run_xfer(input logic [9:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int psel_n, output int acc_n, output logic stable);
        lat = -1; psel_n = 0; acc_n = 0; stable = 1'b1; rd = 'x; er = 1'bx;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (n > 1) @(negedge clk);
            if (psel) begin
                psel_n++;
                if (paddr !== a || pwrite !== w || pwdata !== d) stable = 1'b0;
            end
            if (psel && penable) acc_n++;
            if (rsp_valid) begin
                lat = n; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h pwdata=%h rsp=%b err=%b rdata=%h, need all 0",
                               psel, penable, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", cmd_ready); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er, st; int lat, pn, an;
        run_xfer(10'h000, 1'b1, 32'h1234_5678, rd, er, lat, pn, an, st);
        checks++;
        if ({rd, er} !== {32'h0, 1'b0}) begin errors++; $display("FAIL wr0_rsp: got rdata=%h err=%b need 00000000/0", rd, er); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wr0_latency: got cycle %0d need 4", lat); end
        checks++;
        if (pn !== 3 || !st) begin errors++; $display("FAIL wr0_psel: got psel cycles %0d stable %b need 3/1", pn, st); end
        run_xfer(10'h000, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if ({rd, er} !== {32'h1234_5678, 1'b0}) begin errors++; $display("FAIL rd0_rsp: got rdata=%h err=%b need 12345678/0", rd, er); end
        checks++;
        if (lat !== 4 || an !== 2) begin errors++; $display("FAIL rd0_timing: got rsp cycle %0d access %0d need 4/2", lat, an); end
        // Response values hold after the pulse.
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== {1'b0, 32'h1234_5678, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rsp_hold: got valid=%b rdata=%h err=%b ready=%b need 0/12345678/0/1",
                               rsp_valid, rsp_rdata, rsp_err, cmd_ready);
        end
    endtask

    task automatic test_bypass;
        logic [31:0] rd; logic er, st; int lat, pn, an;
        run_xfer(10'h070, 1'b1, 32'h0000_000F, rd, er, lat, pn, an, st);
        checks++;
        if (pn !== 3 || !st || rd !== 32'h0) begin errors++; $display("FAIL byp_wr: got psel %0d stable %b rdata %h need 3/1/0", pn, st, rd); end
        run_xfer(10'h070, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if (pn !== 3 || rd !== 32'h0000_000F || er !== 1'b0) begin
            errors++; $display("FAIL byp_rd: got psel %0d rdata %h err %b need 3/0000000f/0", pn, rd, er);
        end
    endtask

    task automatic test_back_to_back;
        int rsp_a = -1; int rsp_b = -1; logic st_a = 1'b1; logic st_b = 1'b1;
        logic [31:0] rd; logic er, st; int lat, pn, an;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 10'h010; cmd_write = 1'b1; cmd_wdata = 32'hA5A5_0001;
        @(posedge clk);
        @(negedge clk);
        // Second command presented while busy; must be ignored until IDLE.
        cmd_addr = 10'h048; cmd_wdata = 32'h5A5A_0002;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (psel && (paddr !== 10'h010 || pwdata !== 32'hA5A5_0001)) st_a = 1'b0;
            if (rsp_valid) begin rsp_a = n; break; end
        end
        checks++;
        if (rsp_a !== 4 || !st_a || psel !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got rsp cycle %0d stable %b psel %b need 4/1/0", rsp_a, st_a, psel);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({psel, penable, paddr, pwdata} !== {1'b1, 1'b0, 10'h048, 32'h5A5A_0002}) begin
            errors++; $display("FAIL b2b_rise5: got psel=%b pen=%b paddr=%h pwdata=%h need 1/0/048/5a5a0002",
                               psel, penable, paddr, pwdata);
        end
        for (int n = 6; n <= 20; n++) begin
            @(negedge clk);
            if (psel && (paddr !== 10'h048 || pwdata !== 32'h5A5A_0002)) st_b = 1'b0;
            if (rsp_valid) begin rsp_b = n; break; end
        end
        checks++;
        if (rsp_b !== 8 || !st_b || rsp_err !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got rsp cycle %0d stable %b err %b need 8/1/0", rsp_b, st_b, rsp_err);
        end
        run_xfer(10'h048, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if (rd !== 32'h5A5A_0002) begin errors++; $display("FAIL b2b_readback: got %h need 5a5a0002", rd); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd; logic er, st; int lat, pn, an;
        comp_mode = 1;
        run_xfer(10'h020, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0} || an !== 16 || lat !== 18) begin
            errors++; $display("FAIL timeout: got err %b rdata %h access %0d rsp cycle %0d need 1/0/16/18", er, rd, an, lat);
        end
        comp_mode = 0;
        run_xfer(10'h000, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if ({er, rd} !== {1'b0, 32'h1234_5678} || lat !== 4) begin
            errors++; $display("FAIL after_timeout: got err %b rdata %h cycle %0d need 0/12345678/4", er, rd, lat);
        end
    endtask

    task automatic test_last_cycle;
        logic [31:0] rd; logic er, st; int lat, pn, an;
        comp_mode = 2; ready_at = 15;
        run_xfer(10'h070, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if ({er, rd} !== {1'b0, 32'h0000_000F} || an !== 16) begin
            errors++; $display("FAIL last_cycle: got err %b rdata %h access %0d need 0/0000000f/16", er, rd, an);
        end
        comp_mode = 0;
    endtask

    task automatic test_reset_mid;
        int seen = 0; logic [31:0] rd; logic er, st; int lat, pn, an;
        comp_mode = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 10'h06A; cmd_write = 1'b1; cmd_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 0; n < 10 && !penable; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (!(psel && penable)) begin errors++; $display("FAIL mid_access: got psel=%b pen=%b need 1/1", psel, penable); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++; $display("FAIL mid_reset_clear: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rdata=%h need all 0",
                               psel, penable, pwrite, paddr, pwdata, rsp_rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        comp_mode = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready: got ready=%b psel=%b need 1/0", cmd_ready, psel);
        end
        for (int n = 0; n < 4; n++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL post_reset_rsp: got %0d pulses need 0", seen); end
        run_xfer(10'h06A, 1'b0, 32'h0, rd, er, lat, pn, an, st);
        checks++;
        if ({rd, er} !== {32'h0, 1'b0} || lat !== 4) begin
            errors++; $display("FAIL post_reset_read: got rdata %h err %b cycle %0d need 0/0/4", rd, er, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_timeout();
        test_last_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: APB address width.
REQ-002 Parameter DATA_WIDTH, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles before abort; 0 disables the abort.
REQ-004 clk  in  1  clock; all state is updated on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 i_cmd_valid  in  1  a command is presented.
REQ-007 o_cmd_ready  out  1  the block can accept a command.
REQ-008 i_cmd_addr  in  ADDR_WIDTH  target register address.
REQ-009 i_cmd_write  in  1  1 = write, 0 = read.
REQ-010 i_cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 o_rsp_valid  out  1  single-cycle completion pulse.
REQ-012 o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborts.
REQ-013 o_rsp_err  out  1  transfer aborted by timeout.
REQ-014 o_PADDR / o_PSEL / o_PENABLE / o_PWRITE / o_PWDATA  out  ADDR_WIDTH / 1 / 1 / 1 / DATA_WIDTH  APB requester outputs.
REQ-015 i_PREADY / i_PRDATA  in  1 / DATA_WIDTH  APB completer inputs.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS.
REQ-017 o_cmd_ready shall be 1 only in IDLE, decoded combinationally from the state.
REQ-018 On i_cmd_valid & o_cmd_ready at an edge, the FSM shall go to SETUP and register addr/write/wdata onto o_PADDR/o_PWRITE/o_PWDATA; i_cmd_valid outside IDLE shall be ignored.
REQ-019 SETUP shall last exactly one cycle with PSEL=1, PENABLE=0; the next state is always ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; o_PADDR, o_PWRITE and o_PWDATA shall stay stable from SETUP until the transfer ends.
REQ-021 i_PREADY shall be sampled only in ACCESS; when it is high, the FSM shall go to IDLE and drop PSEL and PENABLE at the same edge.
REQ-022 At that edge, o_rsp_valid shall be set for exactly one cycle, with o_rsp_err=0 and o_rsp_rdata = i_PRDATA for reads or 0 for writes.
REQ-023 A wait counter shall clear on entry to ACCESS and increment each ACCESS cycle that has i_PREADY=0.
REQ-024 When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with i_PREADY still 0, the transfer shall abort: go to IDLE, drop PSEL/PENABLE, and pulse o_rsp_valid with o_rsp_err=1 and o_rsp_rdata=0.
REQ-025 If i_PREADY=1 in the same cycle the timeout would fire, the transfer shall complete normally with o_rsp_err=0.
REQ-026 Latency against a completer that registers PREADY one cycle after PSEL&PENABLE:
  - command accepted at edge E0
  - SETUP in cycle 1, ACCESS in cycles 2-3
  - o_rsp_valid in cycle 4
REQ-027 o_cmd_ready shall be 1 in the o_rsp_valid cycle, allowing a back-to-back command; that command's PSEL rises in cycle 5.
REQ-028 Responses shall not be back-pressured; o_rsp_rdata and o_rsp_err shall hold their values until the next response.

Reset
REQ-029 On rstn low, state=IDLE and every output register shall clear asynchronously: o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, wait counter=0.
REQ-030 Reset asserted mid-transfer shall abandon the transfer with no response pulse; o_cmd_ready=1 in the first cycle after release.

Structure
REQ-031 A shared package apb_pkg shall hold the state enum, the ADDR/DATA width defaults, and the image-filter register-map address constants (CSC 0x00-0x0A, ICSC 0x10-0x1A, FILTER1 0x20-0x44, FILTER2 0x48-0x6A, BYPASS 0x70), shared with the completer.
REQ-032 The block shall be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-033 Write 0x12345678 to 0x000, then read 0x000 (completer attached) -> read rsp_rdata=0x12345678, err=0; write response shows rsp_rdata=0.
REQ-034 Write 0x0000000F to 0x070, then read -> rsp_rdata=0x0000000F; PSEL high exactly 3 cycles per transfer.
REQ-035 i_cmd_valid held high with two commands back-to-back -> second PSEL rise in cycle 5; PADDR/PWDATA stable throughout each transfer.
REQ-036 i_PREADY tied 0, TIMEOUT=16 -> o_rsp_valid with err=1 and rdata=0 after 16 ACCESS cycles; next command accepted normally.
REQ-037 rstn pulsed low during ACCESS -> all outputs 0 at once, no rsp pulse, o_cmd_ready=1 after release.
REQ-038 i_PREADY rises in the last allowed ACCESS cycle -> normal completion with err=0.
